// File: rtl/if_stage_pf.sv
// Instruction-fetch stage with a small prefetch FIFO in front of the ID stage.
// Issues single-outstanding Wishbone-classic reads, buffers the responses and
// hands them to ID under ready/valid. It also handles redirects, including
// draining a read that was in flight when the redirect arrived, and reports
// misaligned and bus-error fetches.
module if_stage_pf #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] iport_addr_o,
   output logic        iport_cyc_o,
   output logic        iport_stb_o,
   input  logic [31:0] iport_data_i,
   input  logic        iport_ack_i,
   input  logic        iport_err_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_pc_add4_o,
   output logic [31:0] id_instruction_o,
   output logic        id_exc_addr_o,
   output logic        id_exc_fault_o,
   output logic        id_valid_o,
   input  logic        id_ready_i
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {StReq, StDrop, StHalt} state_e;

   state_e          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   // Address of the read still on the bus while its response is being dropped
   logic [31:0]     drop_addr_q, drop_addr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   count_q, count_d;

   logic [31:0]     pc_mem_q    [FIFO_DEPTH];
   logic [31:0]     instr_mem_q [FIFO_DEPTH];
   logic            exc_mem_q   [FIFO_DEPTH];
   logic            fault_mem_q [FIFO_DEPTH];

   logic            stb;
   logic            push;
   logic            pop;
   logic            wr_en;
   logic [PtrW-1:0] wr_idx;
   logic [31:0]     wr_pc;
   logic [31:0]     wr_instr;
   logic            wr_exc;
   logic            wr_fault;

   assign id_valid_o = (count_q != '0);
   assign pop        = id_valid_o & id_ready_i;

   // Bus request decode; the reset input gates the strobe so it drops asynchronously
   always_comb begin
      stb          = 1'b0;
      iport_addr_o = fetch_pc_q;
      unique case (state_q)
         StReq:  stb = (count_q != DepthCnt);
         StDrop: begin
            stb          = 1'b1;
            iport_addr_o = drop_addr_q;
         end
         default: stb = 1'b0;
      endcase
   end

   assign iport_cyc_o = stb & rst_i;
   assign iport_stb_o = stb & rst_i;

   // Next-state: redirect first, then per-state response handling and FIFO bookkeeping
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      push        = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = wr_ptr_q;
      wr_pc       = fetch_pc_q;
      wr_instr    = iport_data_i;
      wr_exc      = 1'b0;
      wr_fault    = 1'b0;

      if (redirect_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = redirect_pc_i;
         if (redirect_pc_i[1:0] != 2'b00) begin
            // Misaligned target: report it as the only entry and never request it
            wr_en    = 1'b1;
            wr_idx   = '0;
            wr_pc    = redirect_pc_i;
            wr_instr = NOP_INSTR;
            wr_exc   = 1'b1;
            wr_ptr_d = PtrW'(1);
            count_d  = (PtrW + 1)'(1);
            state_d  = StHalt;
         end else if (stb && !iport_ack_i && !iport_err_i) begin
            state_d = StDrop;
            if (state_q != StDrop) begin
               drop_addr_d = fetch_pc_q;
            end
         end else begin
            state_d = StReq;
         end
      end else begin
         unique case (state_q)
            StReq: begin
               if (stb && iport_err_i) begin
                  push     = 1'b1;
                  wr_instr = NOP_INSTR;
                  wr_fault = 1'b1;
                  state_d  = StHalt;
               end else if (stb && iport_ack_i) begin
                  push       = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end
            StDrop: begin
               if (iport_ack_i || iport_err_i) begin
                  state_d = StReq;
               end
            end
            default: state_d = StHalt;
         endcase

         wr_en = push;
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= StReq;
         fetch_pc_q  <= RESET_ADDR;
         drop_addr_q <= RESET_ADDR;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // FIFO storage; contents are only observed through the valid-masked outputs
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         pc_mem_q[wr_idx]    <= wr_pc;
         instr_mem_q[wr_idx] <= wr_instr;
         exc_mem_q[wr_idx]   <= wr_exc;
         fault_mem_q[wr_idx] <= wr_fault;
      end
   end

   // Head entry presented to ID, zeroed when the FIFO is empty
   always_comb begin
      id_pc_o          = '0;
      id_pc_add4_o     = '0;
      id_instruction_o = '0;
      id_exc_addr_o    = 1'b0;
      id_exc_fault_o   = 1'b0;
      if (id_valid_o) begin
         id_pc_o          = pc_mem_q[rd_ptr_q];
         id_pc_add4_o     = pc_mem_q[rd_ptr_q] + 32'd4;
         id_instruction_o = instr_mem_q[rd_ptr_q];
         id_exc_addr_o    = exc_mem_q[rd_ptr_q];
         id_exc_fault_o   = fault_mem_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_if_stage_pf.sv
// Directed bench for if_stage_pf: a latency-configurable memory model drives the
// instruction port, expected ID entries are queued per step and compared as ID
// accepts them.
module tb_if_stage_pf;

   localparam logic [31:0] RA  = 32'h0000_0100;
   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
      logic        fault;
   } ent_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] iport_addr_o;
   logic        iport_cyc_o;
   logic        iport_stb_o;
   logic [31:0] iport_data_i;
   logic        iport_ack_i;
   logic        iport_err_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_pc_add4_o;
   logic [31:0] id_instruction_o;
   logic        id_exc_addr_o;
   logic        id_exc_fault_o;
   logic        id_valid_o;
   logic        id_ready_i;

   ent_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          lat = 0;
   int          wcnt = 0;
   int          ack_cnt = 0;
   int          saw_202 = 0;
   logic [31:0] err_addr = 32'hFFFF_FFF0;
   int          a0;

   if_stage_pf #(
      .RESET_ADDR(RA),
      .FIFO_DEPTH(4),
      .NOP_INSTR (NOP)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .redirect_i      (redirect_i),
      .redirect_pc_i   (redirect_pc_i),
      .iport_addr_o    (iport_addr_o),
      .iport_cyc_o     (iport_cyc_o),
      .iport_stb_o     (iport_stb_o),
      .iport_data_i    (iport_data_i),
      .iport_ack_i     (iport_ack_i),
      .iport_err_i     (iport_err_i),
      .id_pc_o         (id_pc_o),
      .id_pc_add4_o    (id_pc_add4_o),
      .id_instruction_o(id_instruction_o),
      .id_exc_addr_o   (id_exc_addr_o),
      .id_exc_fault_o  (id_exc_fault_o),
      .id_valid_o      (id_valid_o),
      .id_ready_i      (id_ready_i)
   );

   always #5 clk_i = ~clk_i;

   // Memory model: responds after lat wait cycles, data = addr ^ KEY, err at err_addr
   assign iport_data_i = iport_addr_o ^ KEY;
   assign iport_ack_i  = iport_stb_o && (wcnt >= lat) && (iport_addr_o != err_addr);
   assign iport_err_i  = iport_stb_o && (wcnt >= lat) && (iport_addr_o == err_addr);

   always @(posedge clk_i) begin
      if (!iport_stb_o || iport_ack_i || iport_err_i) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (iport_ack_i) ack_cnt <= ack_cnt + 1;
      if (iport_stb_o && iport_addr_o == 32'h0000_0202) saw_202 <= saw_202 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] instr,
                               input logic exc, input logic fault);
      ent_t e;
      e.pc    = pc;
      e.instr = instr;
      e.exc   = exc;
      e.fault = fault;
      return e;
   endfunction

   task automatic push_fetch(input logic [31:0] pc);
      sb_q.push_back(mk(pc, pc ^ KEY, 1'b0, 1'b0));
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_drain(input int max);
      for (int i = 0; i < max && sb_q.size() != 0; i++) tick();
      chk("drain_left", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic wait_cyc(input int max);
      for (int i = 0; i < max && !iport_cyc_o; i++) tick();
      chk("wait_cyc", {31'b0, iport_cyc_o}, 32'd1);
   endtask

   // Scoreboard: every ID handshake is compared with the oldest expected entry
   always @(negedge clk_i) begin
      ent_t e;
      if (rst_i && id_valid_o && id_ready_i && sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("id_pc", id_pc_o, e.pc);
         chk("id_pc_add4", id_pc_add4_o, e.pc + 32'd4);
         chk("id_instr", id_instruction_o, e.instr);
         chk("id_exc_addr", {31'b0, id_exc_addr_o}, {31'b0, e.exc});
         chk("id_exc_fault", {31'b0, id_exc_fault_o}, {31'b0, e.fault});
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      rst_i         = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      id_ready_i    = 1'b1;

      // Reset values, then zero-wait streaming
      tick();
      @(negedge clk_i);
      chk("rst_cyc", {31'b0, iport_cyc_o}, 32'd0);
      chk("rst_stb", {31'b0, iport_stb_o}, 32'd0);
      chk("rst_addr", iport_addr_o, RA);
      chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
      chk("rst_pc", id_pc_o, 32'd0);
      chk("rst_instr", id_instruction_o, 32'd0);
      chk("rst_add4", id_pc_add4_o, 32'd0);
      for (int i = 0; i < 4; i++) push_fetch(RA + 32'(4 * i));
      tick();
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("s_addr0", iport_addr_o, 32'h100);
      chk("s_cyc0", {31'b0, iport_cyc_o}, 32'd1);
      tick();
      @(negedge clk_i);
      chk("s_addr1", iport_addr_o, 32'h104);
      chk("s_head_pc", id_pc_o, 32'h100);
      tick();
      @(negedge clk_i);
      chk("s_addr2", iport_addr_o, 32'h108);
      wait_drain(20);

      // Asynchronous reset while streaming, then backpressure fills the FIFO
      rst_i      = 1'b0;
      id_ready_i = 1'b0;
      #1;
      chk("arst_cyc", {31'b0, iport_cyc_o}, 32'd0);
      chk("arst_valid", {31'b0, id_valid_o}, 32'd0);
      sb_q.delete();
      tick();
      tick();
      a0    = ack_cnt;
      rst_i = 1'b1;
      repeat (10) tick();
      chk("bp_acks", 32'(ack_cnt - a0), 32'd4);
      @(negedge clk_i);
      chk("bp_cyc", {31'b0, iport_cyc_o}, 32'd0);
      chk("bp_valid", {31'b0, id_valid_o}, 32'd1);
      chk("bp_head", id_pc_o, 32'h100);
      for (int i = 0; i < 5; i++) push_fetch(RA + 32'(4 * i));
      tick();
      id_ready_i = 1'b1;
      wait_cyc(5);
      chk("bp_resume", iport_addr_o, 32'h110);
      wait_drain(20);

      // Redirect during a slow read: old response dropped
      rst_i = 1'b0;
      sb_q.delete();
      lat = 3;
      tick();
      tick();
      rst_i = 1'b1;
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h200;
      tick();
      redirect_i = 1'b0;
      @(negedge clk_i);
      chk("drop_cyc", {31'b0, iport_cyc_o}, 32'd1);
      chk("drop_addr", iport_addr_o, 32'h100);
      tick();
      @(negedge clk_i);
      chk("drop_cyc2", {31'b0, iport_cyc_o}, 32'd1);
      chk("drop_addr2", iport_addr_o, 32'h100);
      tick();
      push_fetch(32'h200);
      push_fetch(32'h204);
      @(negedge clk_i);
      chk("drop_new_addr", iport_addr_o, 32'h200);
      chk("drop_valid", {31'b0, id_valid_o}, 32'd0);
      wait_drain(40);

      // Misaligned redirect
      rst_i = 1'b0;
      sb_q.delete();
      lat = 0;
      tick();
      tick();
      rst_i = 1'b1;
      repeat (3) tick();
      id_ready_i    = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h202;
      tick();
      redirect_i = 1'b0;
      id_ready_i = 1'b1;
      sb_q.push_back(mk(32'h202, NOP, 1'b1, 1'b0));
      @(negedge clk_i);
      chk("mis_valid", {31'b0, id_valid_o}, 32'd1);
      chk("mis_cyc", {31'b0, iport_cyc_o}, 32'd0);
      repeat (3) tick();
      @(negedge clk_i);
      chk("mis_halt_cyc", {31'b0, iport_cyc_o}, 32'd0);
      chk("mis_halt_valid", {31'b0, id_valid_o}, 32'd0);
      chk("mis_no_req", 32'(saw_202), 32'd0);
      tick();
      id_ready_i    = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h300;
      tick();
      redirect_i = 1'b0;
      id_ready_i = 1'b1;
      push_fetch(32'h300);
      push_fetch(32'h304);
      @(negedge clk_i);
      chk("mis_resume_addr", iport_addr_o, 32'h300);
      chk("mis_resume_cyc", {31'b0, iport_cyc_o}, 32'd1);
      wait_drain(20);

      // Bus error on 0x108, then redirect near the top of the address space
      rst_i = 1'b0;
      sb_q.delete();
      err_addr = 32'h108;
      tick();
      tick();
      push_fetch(32'h100);
      push_fetch(32'h104);
      sb_q.push_back(mk(32'h108, NOP, 1'b0, 1'b1));
      rst_i = 1'b1;
      wait_drain(20);
      repeat (3) tick();
      @(negedge clk_i);
      chk("err_halt_cyc", {31'b0, iport_cyc_o}, 32'd0);
      chk("err_halt_valid", {31'b0, id_valid_o}, 32'd0);
      tick();
      id_ready_i    = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFF8;
      tick();
      redirect_i = 1'b0;
      id_ready_i = 1'b1;
      push_fetch(32'hFFFF_FFF8);
      push_fetch(32'hFFFF_FFFC);
      push_fetch(32'h0000_0000);
      push_fetch(32'h0000_0004);
      @(negedge clk_i);
      chk("wrap_addr", iport_addr_o, 32'hFFFF_FFF8);
      wait_drain(20);

      // Reset mid-transfer with two buffered entries
      rst_i = 1'b0;
      sb_q.delete();
      err_addr   = 32'hFFFF_FFF0;
      lat        = 1;
      id_ready_i = 1'b0;
      tick();
      tick();
      a0    = ack_cnt;
      rst_i = 1'b1;
      for (int i = 0; i < 20 && (ack_cnt - a0) != 2; i++) tick();
      chk("mid_acks", 32'(ack_cnt - a0), 32'd2);
      chk("mid_valid_pre", {31'b0, id_valid_o}, 32'd1);
      chk("mid_cyc_pre", {31'b0, iport_cyc_o}, 32'd1);
      rst_i = 1'b0;
      #1;
      chk("mid_cyc", {31'b0, iport_cyc_o}, 32'd0);
      chk("mid_stb", {31'b0, iport_stb_o}, 32'd0);
      chk("mid_valid", {31'b0, id_valid_o}, 32'd0);
      tick();
      lat        = 0;
      id_ready_i = 1'b1;
      push_fetch(32'h100);
      push_fetch(32'h104);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("mid_restart_addr", iport_addr_o, RA);
      chk("mid_restart_valid", {31'b0, id_valid_o}, 32'd0);
      wait_drain(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage_pf.md
Name: if_stage_pf

Overview:
Parametrised instruction-fetch stage with a prefetch buffer. It is the successor to if_stage and adds:
- a Wishbone-classic instruction port, one request outstanding at a time;
- a FIFO_DEPTH-entry prefetch FIFO;
- PC redirect with flush;
- ready/valid backpressure from ID;
- misaligned-address and bus-error exceptions.

It sits between instruction memory and the ID stage.

Parameters:
RESET_ADDR  32'h0000_0000  first fetch PC after reset
FIFO_DEPTH  2  prefetch entries; power of two, >= 2
NOP_INSTR  32'h0000_0013  instruction word delivered with exception entries

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
redirect_i  in  1  load new PC (branch/jump/trap), flush buffer
redirect_pc_i  in  32  target PC for redirect
iport_addr_o  out  32  instruction memory address
iport_cyc_o  out  1  bus cycle active
iport_stb_o  out  1  request strobe (equal to cyc_o)
iport_data_i  in  32  read data, valid with ack
iport_ack_i  in  1  transfer complete
iport_err_i  in  1  bus error terminates transfer
id_pc_o  out  32  PC of head entry
id_pc_add4_o  out  32  id_pc_o + 4, mod 2^32
id_instruction_o  out  32  instruction of head entry
id_exc_addr_o  out  1  head entry has a misaligned fetch address
id_exc_fault_o  out  1  head entry has a bus error
id_valid_o  out  1  head entry valid
id_ready_i  in  1  ID accepts head entry

Behaviour:
Reset (rst_i low, asynchronous):
- state=REQ, fetch_pc=RESET_ADDR, FIFO empty.
- cyc/stb=0, iport_addr_o=RESET_ADDR.
- id_valid_o=0; all id_* data outputs 0.

While rst_i is low:
- cyc/stb are forced 0.
- Release takes effect at the first rising edge with rst_i high.

FIFO:
- Each entry holds {pc, instr, exc_addr, fault}.
- id_valid_o = count!=0.
- All id_* data outputs are driven 0 when !id_valid_o.
- Pop when id_valid_o && id_ready_i.
- Push and pop may happen in the same cycle; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

States:
- REQ
  - cyc=stb=(count<FIFO_DEPTH); addr=fetch_pc.
  - ack while stb: push {fetch_pc, iport_data_i, 0, 0}; fetch_pc += 4.
  - err while stb: push {fetch_pc, NOP_INSTR, 0, 1}; go HALT.
  - When count==FIFO_DEPTH, no request is issued; stb stays low until a pop.
  - If count==FIFO_DEPTH-1 and a pop and a push coincide, the next request is issued the following cycle.
- DROP
  - cyc=stb=1; addr holds the old PC.
  - On ack or err: discard the response; go REQ.
- HALT
  - cyc=stb=0. Leave only on redirect_i.

Redirect (highest priority, any state):
- FIFO is flushed; id_valid_o=0 next cycle. A same-cycle pop or push is ignored.
- fetch_pc <= redirect_pc_i.
- If redirect_pc_i[1:0]!=0:
  - push {redirect_pc_i, NOP_INSTR, 1, 0} into the flushed FIFO;
  - go HALT; no bus request to the misaligned address.
- Otherwise, next state is:
  - DROP if a cycle is in progress (stb=1) with no ack/err this cycle;
  - REQ otherwise, including when redirect coincides with ack/err (that response is discarded, not pushed).
- A redirect during DROP stays in DROP with the new fetch_pc.

Timing:
- A request can be presented from the first cycle after reset release.
- Ack in cycle N gives id_valid_o=1 in cycle N+1.
- Zero-wait memory (ack in the same cycle as stb) with id_ready_i=1 sustains one instruction per cycle.
- fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.

Test Plan:
- Reset with RESET_ADDR=32'h100, zero-wait memory returning addr^32'hA5A5_0000, id_ready_i=1 -> addresses 0x100, 0x104, 0x108 on consecutive cycles. id_pc_o/id_instruction_o follow one cycle later; id_pc_add4_o=0x104 when id_pc_o=0x100.
- id_ready_i=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 acks accepted, then stb=0. On ready=1, entries 0x100..0x10C drain in order and fetching resumes at 0x110.
- Memory with 3-cycle ack latency; redirect_i to 0x200 on cycle 1 of the wait -> state DROP, cyc held until ack. That response is never delivered; the next request addr=0x200 and the first valid id_pc_o=0x200.
- Redirect to 0x202 -> no request to 0x202. One entry {pc=0x202, instr=0x00000013, exc_addr=1}, then cyc=0. A subsequent redirect to 0x300 resumes fetch.
- iport_err_i on fetch of 0x108 -> entry pc=0x108, fault=1, instr=NOP_INSTR delivered after 0x104. cyc=0 afterwards until redirect.
- Assert rst_i low mid-transfer with FIFO holding 2 entries -> cyc/stb/id_valid_o drop immediately (asynchronously). After release, fetching restarts at RESET_ADDR with the FIFO empty.
